// File: rtl/bin_to_onehot_seq_if.sv
// Handshake and output bundle for the binary-to-one-hot hold decoder.
// master = code source / output consumer, slave = the decoder itself.
interface bin_to_onehot_seq_if #(
  parameter int N = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        bin;
  logic                cancel;
  logic [(1<<N)-1:0]   hot;
  logic                busy;
  logic                done;

  modport master (
    output in_valid,
    output bin,
    output cancel,
    input  in_ready,
    input  hot,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  bin,
    input  cancel,
    output in_ready,
    output hot,
    output busy,
    output done
  );
endinterface

// File: rtl/bin_to_onehot_seq.sv
// Registered binary-to-one-hot decoder with valid/ready intake and a timed
// output hold. Each accepted code drives one bit of hot for HOLD_CYCLES
// clocks; a new code may be accepted on the last hold cycle so consecutive
// codes stream with no idle gap. The latched code lives only in hot_q, which
// is the one-hot image of the accepted bin.
module bin_to_onehot_seq #(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bin_to_onehot_seq_if.slave    bus
);

  localparam int                W    = 1 << N;
  localparam int                CW   = 8;
  localparam logic [CW-1:0]     LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    hot_q;
  logic            done_q;

  logic [W-1:0]    dec_d;
  logic            last_d;
  logic            ready_d;
  logic            accept_d;

  // Decode the incoming code into its one-hot image, one compare per bit.
  for (genvar gi = 0; gi < W; gi++) begin : g_dec
    assign dec_d[gi] = (bus.bin == N'(gi));
  end

  assign last_d   = (state_q == HOLD) && (cnt_q == LAST);
  assign ready_d  = !bus.cancel && ((state_q == IDLE) || last_d);
  assign accept_d = bus.in_valid && ready_d;

  // Control FSM: the hold counter runs from 0 to LAST, done_q is raised when
  // the counter is about to reach LAST so it coincides with the final hot cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hot_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q <= HOLD;
            hot_q   <= dec_d;
            cnt_q   <= '0;
            done_q  <= (LAST == '0);
          end
        end
        HOLD: begin
          if (bus.cancel) begin
            state_q <= IDLE;
            hot_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end else if (last_d) begin
            if (accept_d) begin
              // Seamless hand-over: old bit drops and new bit rises on one edge.
              state_q <= HOLD;
              hot_q   <= dec_d;
              cnt_q   <= '0;
              done_q  <= (LAST == '0);
            end else begin
              state_q <= IDLE;
              hot_q   <= '0;
              cnt_q   <= '0;
              done_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            done_q <= ((cnt_q + CW'(1)) == LAST);
          end
        end
        default: begin
          state_q <= IDLE;
          hot_q   <= '0;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // A cancel on the final hold cycle aborts the code, so its done is withheld.
  assign bus.done     = done_q && !bus.cancel;
  assign bus.hot      = hot_q;
  assign bus.busy     = (state_q == HOLD);
  assign bus.in_ready = ready_d;

endmodule
